// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the SRAM recorder slice.
// Holds the recorder state enum, LCD state codes, I2S framing constants
// and a saturating absolute-value helper used by the optional peak meter.
package audio_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned LRCK_DELAY = 1;

  typedef enum logic [1:0] {
    REC_IDLE,
    REC_STOP,
    REC_RECORD,
    REC_PAUSE
  } rec_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DELAY,
    RX_SHIFT
  } rx_phase_e;

  localparam logic [3:0] STATE_IDLE  = 4'b1000;
  localparam logic [3:0] STATE_STOP  = 4'b0100;
  localparam logic [3:0] STATE_REC   = 4'b0101;
  localparam logic [3:0] STATE_PAUSE = 4'b0110;

  function automatic logic [3:0] state_code(input rec_state_e s);
    logic [3:0] c;
    case (s)
      REC_IDLE:   c = STATE_IDLE;
      REC_STOP:   c = STATE_STOP;
      REC_RECORD: c = STATE_REC;
      REC_PAUSE:  c = STATE_PAUSE;
      default:    c = STATE_IDLE;
    endcase
    return c;
  endfunction

  // |s| for a two's complement sample; the most negative value saturates
  // to the most positive one so the result always fits in SAMPLE_W bits.
  function automatic logic [SAMPLE_W-1:0] sample_abs(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] neg;
    logic [SAMPLE_W-1:0] r;
    neg = ~s + 1'b1;
    if (!s[SAMPLE_W-1])
      r = s;
    else if (neg[SAMPLE_W-1])
      r = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else
      r = neg;
    return r;
  endfunction

endpackage

// File: rtl/i2s_rx_shift.sv
// i2s_rx_shift: left-channel I2S deserializer on the bit clock.
// Detects the left frame start (LRCK high->low), skips the one-bit I2S
// delay, shifts 16 bits MSB first and pulses o_valid for one cycle with
// the completed sample. Dropping i_arm abandons any frame in progress.
module i2s_rx_shift
  import audio_pkg::*;
(
  input  logic                i_bclk,
  input  logic                i_rst_n,
  input  logic                i_arm,
  input  logic                i_lrck,
  input  logic                i_dat,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_valid
);

  localparam logic [4:0] DLY_LAST = 5'(LRCK_DELAY - 1);
  localparam logic [4:0] BIT_LAST = 5'(SAMPLE_W - 1);

  logic                r_lrck_d;
  rx_phase_e           r_phase;
  rx_phase_e           w_phase_nx;
  logic [4:0]          r_cnt;
  logic [SAMPLE_W-1:0] r_shift;
  logic                r_valid;
  logic                w_frame_start;
  logic                w_done;

  assign w_frame_start = r_lrck_d & ~i_lrck;
  assign w_done        = (r_phase == RX_SHIFT) && i_arm && (r_cnt == BIT_LAST);
  assign o_sample      = r_shift;
  assign o_valid       = r_valid;

  // Next framing phase: wait for armed frame start, skip delay, shift bits.
  always_comb begin
    w_phase_nx = r_phase;
    case (r_phase)
      RX_IDLE: begin
        if (i_arm && w_frame_start) w_phase_nx = RX_DELAY;
      end
      RX_DELAY: begin
        if (!i_arm)                  w_phase_nx = RX_IDLE;
        else if (r_cnt == DLY_LAST)  w_phase_nx = RX_SHIFT;
      end
      RX_SHIFT: begin
        if (!i_arm)                  w_phase_nx = RX_IDLE;
        else if (r_cnt == BIT_LAST)  w_phase_nx = RX_IDLE;
      end
      default: w_phase_nx = RX_IDLE;
    endcase
  end

  // Phase register, bit counter, shift register and sample-valid strobe.
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lrck_d <= 1'b0;
      r_phase  <= RX_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_lrck_d <= i_lrck;
      r_phase  <= w_phase_nx;
      r_valid  <= w_done;
      if (r_phase != w_phase_nx)
        r_cnt <= '0;
      else if (r_phase != RX_IDLE)
        r_cnt <= r_cnt + 1'b1;
      if (r_phase == RX_SHIFT && i_arm)
        r_shift <= {r_shift[SAMPLE_W-2:0], i_dat};
    end
  end

endmodule

// File: rtl/sram_recorder.sv
// sram_recorder: records the left I2S ADC channel into external SRAM.
// Key pulses drive an IDLE/STOP/RECORD/PAUSE FSM; each captured sample is
// written for one cycle at consecutive addresses and the recorded length
// is exported as o_end_addr for the playback reader.
// Optional feature macro: RECORDER_PEAK_EN (peak |sample| meter on o_peak).
module sram_recorder
  import audio_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 20,
  parameter int unsigned          DATA_W   = 16,
  parameter logic [ADDR_W-1:0]    MAX_ADDR = 20'hFFFFF
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_record,
  input  logic              i_stop,
  input  logic              i_ADCLRCK,
  input  logic              i_ADCDAT,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_SRAM_DQ,
  output logic              o_we_n,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_full,
  output logic [3:0]        o_state,
  output logic [DATA_W-1:0] o_peak
);

  rec_state_e          r_state;
  rec_state_e          w_state_nx;
  logic [3:0]          r_o_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_o_addr;
  logic [DATA_W-1:0]   r_dq;
  logic                r_we_n;
  logic [ADDR_W-1:0]   r_end_addr;
  logic                r_full;
  logic [SAMPLE_W-1:0] w_sample;
  logic                w_valid;
  logic                w_arm;
  logic                w_hit_max;
  logic                w_start_rec;

  assign w_arm       = (r_state == REC_RECORD);
  // The write cycle currently on the bus targets the last address.
  assign w_hit_max   = !r_we_n && (r_addr == MAX_ADDR);
  assign w_start_rec = (r_state == REC_STOP) && (w_state_nx == REC_RECORD);

  i2s_rx_shift u_rx (
    .i_bclk   (i_bclk),
    .i_rst_n  (i_rst_n),
    .i_arm    (w_arm),
    .i_lrck   (i_ADCLRCK),
    .i_dat    (i_ADCDAT),
    .o_sample (w_sample),
    .o_valid  (w_valid)
  );

  // Next state: enable beats memory-full, which beats stop, which beats record.
  always_comb begin
    w_state_nx = r_state;
    if (!i_enable) begin
      w_state_nx = REC_IDLE;
    end else if (w_hit_max) begin
      w_state_nx = REC_STOP;
    end else begin
      case (r_state)
        REC_IDLE:   w_state_nx = REC_STOP;
        REC_STOP:   if (!i_stop && i_record) w_state_nx = REC_RECORD;
        REC_RECORD: begin
          if (i_stop)        w_state_nx = REC_STOP;
          else if (i_record) w_state_nx = REC_PAUSE;
        end
        REC_PAUSE: begin
          if (i_stop)        w_state_nx = REC_STOP;
          else if (i_record) w_state_nx = REC_RECORD;
        end
        default: w_state_nx = REC_IDLE;
      endcase
    end
  end

  // State register and its one-cycle-late LCD code.
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= REC_IDLE;
      r_o_state <= STATE_IDLE;
    end else begin
      r_state   <= w_state_nx;
      r_o_state <= state_code(r_state);
    end
  end

  // SRAM write strobe, address counter, end address and full flag.
  // Bookkeeping runs in the cycle after the strobe; a restart clears it last.
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we_n     <= 1'b1;
      r_dq       <= '0;
      r_o_addr   <= '0;
      r_addr     <= '0;
      r_end_addr <= '0;
      r_full     <= 1'b0;
    end else begin
      r_we_n <= ~w_valid;
      if (w_valid) begin
        r_dq     <= DATA_W'(w_sample);
        r_o_addr <= r_addr;
      end
      if (!r_we_n) begin
        r_end_addr <= r_addr + 1'b1;
        if (r_addr == MAX_ADDR)
          r_full <= 1'b1;
        else
          r_addr <= r_addr + 1'b1;
      end
      if (w_start_rec) begin
        r_addr     <= '0;
        r_o_addr   <= '0;
        r_end_addr <= '0;
        r_full     <= 1'b0;
      end
    end
  end

`ifdef RECORDER_PEAK_EN
  logic [DATA_W-1:0] r_peak;
  logic [DATA_W-1:0] w_abs;

  assign w_abs = DATA_W'(sample_abs(w_sample));

  // Running peak magnitude, updated alongside each SRAM write.
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_peak <= '0;
    end else begin
      if (w_valid && (w_abs > r_peak))
        r_peak <= w_abs;
      if (w_start_rec)
        r_peak <= '0;
    end
  end

  assign o_peak = r_peak;
`else
  assign o_peak = '0;
`endif

  assign o_addr     = r_o_addr;
  assign o_SRAM_DQ  = r_dq;
  assign o_we_n     = r_we_n;
  assign o_end_addr = r_end_addr;
  assign o_full     = r_full;
  assign o_state    = r_o_state;

endmodule

// File: tb/tb_sram_recorder.sv
// tb_sram_recorder: directed, table-driven checks of sram_recorder.
// Instance u1 uses the default memory size; u2 uses MAX_ADDR=4 for the
// full-memory case. Both share clock, reset, enable and the I2S lines.
module tb_sram_recorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, rec1, stp1, rec2, stp2, lrck, dat;
  logic [19:0] addr1, end1, addr2, end2;
  logic [15:0] dq1, pk1, dq2, pk2;
  logic        we1, we2, full1, full2;
  logic [3:0]  st1, st2;

  int total = 0;
  int bad   = 0;

  int          w1_cnt, w1_k, w2_cnt;
  logic [19:0] w1_addr;
  logic [15:0] w1_dq;
  logic [19:0] q2[$];

  typedef struct {
    logic [15:0] smp;
    logic [19:0] addr;
  } vec_t;

  vec_t        tv[3];
  logic [15:0] full_smp[6];
  logic [15:0] exp_pk;

  sram_recorder u1 (
    .i_bclk(clk), .i_rst_n(rst_n), .i_enable(en), .i_record(rec1), .i_stop(stp1),
    .i_ADCLRCK(lrck), .i_ADCDAT(dat), .o_addr(addr1), .o_SRAM_DQ(dq1), .o_we_n(we1),
    .o_end_addr(end1), .o_full(full1), .o_state(st1), .o_peak(pk1)
  );

  sram_recorder #(.ADDR_W(20), .DATA_W(16), .MAX_ADDR(20'h4)) u2 (
    .i_bclk(clk), .i_rst_n(rst_n), .i_enable(en), .i_record(rec2), .i_stop(stp2),
    .i_ADCLRCK(lrck), .i_ADCDAT(dat), .o_addr(addr2), .o_SRAM_DQ(dq2), .o_we_n(we2),
    .o_end_addr(end2), .o_full(full2), .o_state(st2), .o_peak(pk2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One I2S frame of 40 bclks (20 left, 20 right). Iteration k drives the
  // values sampled at rising edge E_k and observes outputs from E_(k-1).
  // rec_k >= 0 pulses u1's record key at edge E_rec_k.
  task automatic frame(input logic [15:0] s, input int rec_k);
    logic [15:0] sv;
    sv = s;
    w1_cnt = 0;
    w1_k   = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (we1 === 1'b0) begin
          w1_cnt++;
          w1_k    = k - 1;
          w1_addr = addr1;
          w1_dq   = dq1;
        end
        if (we2 === 1'b0) begin
          w2_cnt++;
          q2.push_back(addr2);
        end
      end
      lrck = (k < 20) ? 1'b0 : 1'b1;
      dat  = (k >= 2 && k <= 17) ? sv[17-k] : 1'b0;
      rec1 = (k == rec_k);
    end
    @(negedge clk);
  endtask

  task automatic pulse(input logic r1, input logic s1, input logic r2, input logic s2);
    @(negedge clk);
    rec1 = r1; stp1 = s1; rec2 = r2; stp2 = s2;
    @(negedge clk);
    rec1 = 1'b0; stp1 = 1'b0; rec2 = 1'b0; stp2 = 1'b0;
  endtask

  initial begin
    tv[0] = '{16'h1234, 20'd0};
    tv[1] = '{16'h8000, 20'd1};
    tv[2] = '{16'h7FFF, 20'd2};
    full_smp[0] = 16'h0010;
    full_smp[1] = 16'hFFF0;
    full_smp[2] = 16'h8000;
    full_smp[3] = 16'h0001;
    full_smp[4] = 16'h0002;
    full_smp[5] = 16'h1234;

    rst_n = 1'b0; en = 1'b0; rec1 = 1'b0; stp1 = 1'b0; rec2 = 1'b0; stp2 = 1'b0;
    lrck = 1'b1; dat = 1'b0;
    #12;
    chk("rst_addr",  32'(addr1), 32'h0);
    chk("rst_dq",    32'(dq1),   32'h0);
    chk("rst_we_n",  32'(we1),   32'h1);
    chk("rst_end",   32'(end1),  32'h0);
    chk("rst_full",  32'(full1), 32'h0);
    chk("rst_state", 32'(st1),   32'h8);
    chk("rst_peak",  32'(pk1),   32'h0);

    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); en = 1'b1;
    @(negedge clk);
    chk("state_lag_idle", 32'(st1), 32'h8);
    @(negedge clk);
    chk("state_stop", 32'(st1), 32'h4);
    chk("stop_we_n",  32'(we1), 32'h1);
    chk("stop_end",   32'(end1), 32'h0);

    // Three recorded frames from the vector table.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      frame(tv[i].smp, -1);
      chk("wr_count",   32'(w1_cnt),  32'd1);
      chk("wr_latency", 32'(w1_k),    32'd18);
      chk("wr_addr",    32'(w1_addr), 32'(tv[i].addr));
      chk("wr_data",    32'(w1_dq),   32'(tv[i].smp));
      chk("end_addr",   32'(end1),    32'(tv[i].addr) + 32'd1);
      chk("addr_hold",  32'(addr1),   32'(tv[i].addr));
    end
    chk("state_rec", 32'(st1), 32'h5);
`ifdef RECORDER_PEAK_EN
    exp_pk = 16'h7FFF;
`else
    exp_pk = 16'h0000;
`endif
    chk("peak3", 32'(pk1), 32'(exp_pk));

    // Pause at bit 8 of frame 4 discards the partial sample.
    frame(16'hA5A5, 9);
    chk("pause_nowr",  32'(w1_cnt), 32'd0);
    chk("pause_state", 32'(st1),    32'h6);
    chk("pause_end",   32'(end1),   32'd3);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    frame(16'h0F0F, -1);
    chk("resume_cnt",  32'(w1_cnt),  32'd1);
    chk("resume_addr", 32'(w1_addr), 32'd3);
    chk("resume_data", 32'(w1_dq),   32'h0F0F);
    chk("resume_end",  32'(end1),    32'd4);

    // Record and stop together: stop wins, end address held.
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("stopwin_end", 32'(end1), 32'd4);
    @(negedge clk);
    chk("stopwin_state", 32'(st1), 32'h4);
    frame(16'h5555, -1);
    chk("stop_nowr", 32'(w1_cnt), 32'd0);
    chk("stop_hold", 32'(end1),   32'd4);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_end",  32'(end1),  32'd0);
    chk("restart_full", 32'(full1), 32'd0);
    frame(16'hFFFE, -1);
    chk("restart_addr", 32'(w1_addr), 32'd0);
    chk("restart_data", 32'(w1_dq),   32'hFFFE);
    chk("restart_end1", 32'(end1),    32'd1);
`ifdef RECORDER_PEAK_EN
    exp_pk = 16'h0002;
`else
    exp_pk = 16'h0000;
`endif
    chk("restart_peak", 32'(pk1), 32'(exp_pk));

    // Small memory: six frames give exactly five writes then full + STOP.
    w2_cnt = 0;
    q2.delete();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) frame(full_smp[i], -1);
    chk("full_writes", 32'(w2_cnt), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < q2.size()) chk("full_addr", 32'(q2[i]), 32'(i));
    end
    chk("full_flag",  32'(full2), 32'd1);
    chk("full_state", 32'(st2),   32'h4);
    chk("full_end",   32'(end2),  32'd5);
    chk("full_dq",    32'(dq2),   32'h0002);
`ifdef RECORDER_PEAK_EN
    exp_pk = 16'h7FFF;
`else
    exp_pk = 16'h0000;
`endif
    chk("full_peak", 32'(pk2), 32'(exp_pk));

    // Asynchronous reset during the write strobe.
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      lrck = 1'b0;
      dat  = (k >= 2 && k <= 17) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    chk("pre_rst_we_n", 32'(we1), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("arst_we_n",  32'(we1),   32'h1);
    chk("arst_addr",  32'(addr1), 32'h0);
    chk("arst_dq",    32'(dq1),   32'h0);
    chk("arst_end",   32'(end1),  32'h0);
    chk("arst_full",  32'(full1), 32'h0);
    chk("arst_state", 32'(st1),   32'h8);
    chk("arst_peak",  32'(pk1),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    lrck  = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_recorder.md
# sram_recorder

Record-side counterpart of the SRAM playback reader. It deserializes the WM8731 ADC I2S stream on the bit clock and keeps the left channel only. Each 16-bit sample is written to external SRAM at consecutive addresses. The block exports the recorded length as the end address that the playback reader consumes. Record, pause and stop come from debounced key pulses, and the block reports a 4-bit state for the LCD.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, sample width
- MAX_ADDR, 20'hFFFFF, last writable SRAM address

Ports:
- i_bclk  in  1  I2S bit clock; all logic is on its rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  block selected (record mode); low forces IDLE
- i_record  in  1  one-cycle pulse; start/pause/resume
- i_stop  in  1  one-cycle pulse; stop recording
- i_ADCLRCK  in  1  I2S frame clock (0 = left)
- i_ADCDAT  in  1  I2S serial data
- o_addr  out  ADDR_W  SRAM address
- o_SRAM_DQ  out  DATA_W  write data
- o_we_n  out  1  SRAM write enable, active low
- o_end_addr  out  ADDR_W  number of samples recorded (reader's i_end_addr)
- o_full  out  1  memory exhausted, sticky until next record start
- o_state  out  4  1000 idle, 0100 stop, 0101 record, 0110 pause
- o_peak  out  DATA_W  peak |sample| since record start (see Configuration)

## Operation
- States:
  - IDLE: on i_enable → STOP.
  - STOP: on i_record → RECORD; on entry to RECORD, addr, end_addr, o_full and o_peak clear to 0.
  - RECORD: i_record → PAUSE; i_stop → STOP.
  - PAUSE: i_record → RECORD with addr kept; i_stop → STOP.
  - Any state: !i_enable → IDLE.
- Priority, highest first: !i_enable, i_stop, i_record.
- When i_stop and i_record arrive in the same cycle, stop wins.
- Capture:
  - lrck_d registers i_ADCLRCK every cycle.
  - A left frame starts when lrck_d=1 and i_ADCLRCK=0 in the same cycle. The next cycle is the I2S 1-bit delay.
  - The following 16 cycles shift i_ADCDAT in, MSB first, as a 5-bit count 0..15.
  - The right channel is ignored.
- Capture runs only in RECORD. It arms at the first frame start after entering RECORD. A partial frame is never written.
- Write:
  - In the cycle after bit 15, o_SRAM_DQ = sample, o_addr = addr and o_we_n = 0 for exactly one cycle.
  - Next cycle: o_we_n = 1, addr increments by 1 and o_end_addr = addr+1.
- Pause or stop mid-frame: the in-progress sample is discarded; no write occurs.
- A pending write cycle that coincides with a pause or stop still completes.
- Full:
  - The write to MAX_ADDR sets o_full and forces STOP.
  - o_end_addr saturates at MAX_ADDR+1 truncated to ADDR_W. For the default, this equals 0 with o_full=1, which the reader must treat as full length.
- o_end_addr holds its value through STOP, PAUSE and IDLE. It clears only on STOP→RECORD.
- o_addr holds its last value outside writes.

## Timing
- All outputs reset to: o_addr 0, o_SRAM_DQ 0, o_we_n 1, o_end_addr 0, o_full 0, o_state 1000, o_peak 0; state IDLE.
- o_state is registered and changes one cycle after the state transition.
- Latency from the falling edge of i_ADCLRCK (left frame start) to o_we_n low is 18 bclk cycles.
- o_we_n is never low in two consecutive cycles. There is at most one write per LRCK period.
- A reset mid-write releases o_we_n immediately, because reset is asynchronous.

## Configuration
- RECORDER_PEAK_EN defined: o_peak is updated on every write cycle.
  - Update rule: o_peak = max(o_peak, |sample|).
  - |−32768| saturates to 32767.
- RECORDER_PEAK_EN undefined: o_peak is tied to 0 and no comparator logic is built.

## Structure
- Package audio_pkg holds:
  - the recorder state enum;
  - the o_state encoding constants (IDLE 1000, STOP 0100, REC 0101, PAUSE 0110);
  - I2S constants SAMPLE_W=16 and LRCK_DELAY=1.
- Sub-module i2s_rx_shift owns lrck_d, the frame-start detect, the bit counter and the shift register.
  - It outputs a 16-bit sample and a one-cycle valid, with an arm input.
  - The FSM, SRAM write, address counter, end address and peak logic stay in the top.

## Test plan
- Reset then i_enable=1 → o_state 1000 then 0100; o_we_n=1 and o_end_addr=0.
- Pulse i_record, then drive three left frames with samples 16'h1234, 16'h8000, 16'h7FFF → writes at o_addr 0,1,2 with matching data, each 18 cycles after the LRCK falling edge; o_end_addr=3. With RECORDER_PEAK_EN, o_peak=16'h7FFF.
- Pulse i_record at bit 8 of frame 4 → no write, o_state 0110. Pulse i_record again → next full frame is written to addr 3.
- Pulse i_record and i_stop in the same cycle while in RECORD → STOP; o_end_addr held at its value. A later i_record → o_end_addr=0 and the first write goes to addr 0.
- With MAX_ADDR=4, record 6 frames → exactly 5 writes (addr 0..4), then o_full=1 and o_state 0100.
- Assert i_rst_n low during the o_we_n=0 cycle → o_we_n=1 immediately and all outputs take their reset values.
